mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencing controller for the single shared memory port used by fetch, load/store and debug. Accepts requests from three requesters, grants one at a time under round-robin priority, drives the 2-bit select of the 3-input address/write-data mux (`sel`), and handshakes with the memory via `mem_valid`/`mem_ready`. A timeout counter aborts hung transactions and flags an error.

## Interface
- `TIMEOUT`, 16, maximum number of BUSY cycles allowed without `mem_ready`; legal range ≥1.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  request vector; bit 0 = fetch, bit 1 = load/store, bit 2 = debug.
- `gnt`  out  3  one-hot owner of the port; all zero when idle.
- `done`  out  3  one-hot, one-cycle completion pulse to the owner.
- `err`  out  1  one-cycle pulse, coincident with `done`, when the transaction timed out.
- `sel`  out  2  mux select, equal to the owner index; never 2'b11.
- `mem_valid`  out  1  transaction active toward memory.
- `mem_ready`  in  1  memory completes the current transaction this cycle.

## Operation
- States: IDLE, BUSY. Internal registers: `owner` (2b), `last` (2b), `timer` (counter of width $clog2(TIMEOUT+1)).
- Arbitration is round-robin. Search order starts at `last+1` mod 3 and wraps; the first set `req` bit wins.
- IDLE, with any `req` set: pick the winner. At the next edge: BUSY, `owner` = winner, `gnt` = onehot(winner), `sel` = winner, `mem_valid` = 1, `timer` = 0.
- BUSY with `mem_ready` = 0:
  - `timer` increments.
  - In the cycle where `timer` == TIMEOUT-1, the arbiter asserts `done[owner]` and `err`, and treats that cycle as completion.
- Completion cycle (BUSY and (`mem_ready` or timeout)):
  - `done[owner]` = 1 combinationally.
  - `last` <= `owner` at the edge.
  - Arbitration over `req` with the owner's bit masked. If there is a winner, the arbiter stays BUSY with the new grant (no bubble). Otherwise it goes to IDLE: `gnt` = 0, `mem_valid` = 0, and `sel` holds its last value.
- `mem_ready` and timeout in the same cycle count as a normal completion: `err` = 0.
- The owner dropping `req` while BUSY is ignored. The transaction continues to completion and `done` still pulses.
- The owner's `req` still high in the cycle after `done` is a new request, and it competes normally.
- `mem_ready` while IDLE is ignored. No `done` is produced.
- `reset_n` low at any time:
  - Immediate abort with no `done`.
  - State IDLE, `gnt` = 0, `done` = 0, `err` = 0, `sel` = 2'b00, `mem_valid` = 0, `timer` = 0.
  - `last` = 2, so requester 0 has first priority.

## Timing
- Request-to-grant: 1 cycle. `req` is sampled at edge N; `gnt`, `sel` and `mem_valid` are high after edge N.
- Shortest transaction is 1 cycle, when `mem_ready` arrives in the first BUSY cycle.
- Back-to-back grants switch `gnt`/`sel` at the completion edge with no idle cycle.
- `done` and `err` are combinational from registered state plus `mem_ready`, and valid in the same cycle as `mem_ready`.
- `gnt`, `sel` and `mem_valid` are registered outputs.
- Timeout fires exactly TIMEOUT BUSY cycles after the grant edge. With TIMEOUT = 1, every cycle without `mem_ready` times out immediately.
- Worst-case wait for a continuously requesting client: 2 transactions.

## Structure
- Package `mem_arb_pkg`:
  - State enum typedef `arb_state_t` {IDLE, BUSY}.
  - Requester index constants `REQ_IF` = 0, `REQ_MEM` = 1, `REQ_DBG` = 2.
  - Constant `NUM_REQ` = 3.
- Sub-module `rr_pick3`: combinational. Inputs are `req[2:0]` and `last[1:0]`. Outputs are `winner[1:0]` and `any`. It is instantiated once and fed the masked request vector.

## Test plan
- Reset then `req` = 3'b001, `mem_ready` = 1 in the first BUSY cycle:
  - Next edge gives `gnt` = 001, `sel` = 0, `mem_valid` = 1.
  - `done` = 001 in the same cycle as `mem_ready`.
  - Returns to IDLE; `sel` stays 0.
- `req` = 3'b111 held, `mem_ready` = 1 every BUSY cycle:
  - Grant sequence is 0, 1, 2, 0, … with no idle cycles.
  - `mem_valid` stays high continuously.
- `req` = 3'b010, `mem_ready` held 0, TIMEOUT = 4:
  - `done` = 010 and `err` = 1 in the 4th BUSY cycle.
  - IDLE next cycle.
- During a BUSY from requester 2, `reset_n` pulses low mid-transaction:
  - All outputs go to reset values asynchronously, with no `done`.
  - After release, `req` = 3'b101 is granted to requester 0 first.
- Requester 1 drops `req` in its second BUSY cycle; `mem_ready` arrives in the 3rd:
  - `done` = 010 still pulses.
  - `mem_valid` is held until completion.
- `mem_ready` pulsed while IDLE with `req` = 0: no `done`, no state change. Check also that `sel` never equals 2'b11 across all scenarios.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose : shared types, requester indices and small helpers for the memory port arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_IF  = 2'd0;
  localparam logic [1:0] REQ_MEM = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;

  // Round-robin successor over the three requesters (2 wraps to 0).
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= REQ_DBG) ? REQ_IF : idx + 2'd1;
  endfunction

  // Index to one-hot; the unused encoding 2'b11 maps to no owner.
  function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    case (idx)
      REQ_IF:  v = 3'b001;
      REQ_MEM: v = 3'b010;
      REQ_DBG: v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Purpose : 3-way round-robin picker; search starts just after `last` and wraps.
// Latency : purely combinational.
// Backpressure: none; caller masks/qualifies the request vector.
// Ports   : req[2:0] candidate requests, last[1:0] previous owner,
//           winner[1:0] chosen index (0 when none), any = at least one request.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               any
);

  logic [1:0] w_cand0;
  logic [1:0] w_cand1;
  logic [1:0] w_cand2;

  always_comb begin
    w_cand0 = next_idx(last);
    w_cand1 = next_idx(w_cand0);
    w_cand2 = next_idx(w_cand1);
    winner  = REQ_IF;
    if (req[w_cand0]) begin
      winner = w_cand0;
    end else if (req[w_cand1]) begin
      winner = w_cand1;
    end else if (req[w_cand2]) begin
      winner = w_cand2;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : round-robin owner of the shared memory port (fetch / load-store / debug) with timeout abort.
// Latency : req->gnt 1 cycle; done/err combinational with mem_ready; back-to-back grants without a bubble.
// Backpressure: the owner holds the port until mem_ready or TIMEOUT BUSY cycles; other requesters wait.
// Ports   : clk, reset_n (async active-low); req[2:0] requests in; gnt[2:0] one-hot owner;
//           done[2:0] completion pulse; err timeout pulse; sel[1:0] mux select;
//           mem_valid / mem_ready transaction handshake with memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  output logic [1:0]         sel,
  output logic               mem_valid,
  input  logic               mem_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  arb_state_t         r_state;
  logic [1:0]         r_owner;
  logic [1:0]         r_last;
  logic [TW-1:0]      r_timer;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_mem_valid;

  logic               w_busy;
  logic               w_timeout;
  logic               w_complete;
  logic [NUM_REQ-1:0] w_req_masked;
  logic [1:0]         w_pick_last;
  logic [1:0]         w_winner;
  logic               w_any;

  assign w_busy     = (r_state == BUSY);
  assign w_timeout  = w_busy && (r_timer == T_LAST);
  assign w_complete = w_busy && (mem_ready || w_timeout);

  // While BUSY the picker is only consulted on the completion cycle. The
  // owner is masked out and the search starts after it, which is exactly the
  // order `last <= owner` would give on the next cycle.
  always_comb begin
    w_req_masked = req;
    w_pick_last  = r_last;
    if (w_busy) begin
      w_req_masked = req & ~onehot3(r_owner);
      w_pick_last  = r_owner;
    end
  end

  rr_pick3 u_pick (
    .req    (w_req_masked),
    .last   (w_pick_last),
    .winner (w_winner),
    .any    (w_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= REQ_IF;
      r_last      <= REQ_DBG;
      r_timer     <= '0;
      r_gnt       <= '0;
      r_mem_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= BUSY;
            r_owner     <= w_winner;
            r_gnt       <= onehot3(w_winner);
            r_mem_valid <= 1'b1;
            r_timer     <= '0;
          end
        end
        BUSY: begin
          if (w_complete) begin
            r_last  <= r_owner;
            r_timer <= '0;
            if (w_any) begin
              r_owner <= w_winner;
              r_gnt   <= onehot3(w_winner);
            end else begin
              // r_owner is left alone so sel keeps its last value while idle.
              r_state     <= IDLE;
              r_gnt       <= '0;
              r_mem_valid <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_owner;
  assign mem_valid = r_mem_valid;
  assign done      = w_complete ? onehot3(r_owner) : '0;
  // A timeout coinciding with mem_ready is a normal completion.
  assign err       = w_timeout && !mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter (TIMEOUT = 4) with a done/err scoreboard.
// Latency : n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] req;
  logic       mem_ready;
  logic [2:0] gnt;
  logic [2:0] done;
  logic       err;
  logic [1:0] sel;
  logic       mem_valid;

  typedef struct packed {
    logic [2:0] done;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_sel11  = 0;
  logic [1:0] m_last;
  logic [1:0] exp_owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .sel       (sel),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] oh(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sel == 2'b11) n_sel11++;
    if (done != 3'b000 || err) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 32'({done, err}), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_done", 32'(done), 32'(e.done));
        chk("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req       = 3'b000;
    mem_ready = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_sel", 32'(sel), 32'(0));
    chk("rst_valid", 32'(mem_valid), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    cyc();
    reset_n = 1'b1;

    // Single-cycle transaction from fetch.
    req = 3'b001;
    cyc();
    req       = 3'b000;
    mem_ready = 1'b1;
    sb_q.push_back({3'b001, 1'b0});
    @(negedge clk);
    chk("s1_gnt", 32'(gnt), 32'(3'b001));
    chk("s1_sel", 32'(sel), 32'(0));
    chk("s1_valid", 32'(mem_valid), 32'(1));
    chk("s1_done", 32'(done), 32'(3'b001));
    cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("s1_idle_gnt", 32'(gnt), 32'(0));
    chk("s1_idle_valid", 32'(mem_valid), 32'(0));
    chk("s1_idle_sel", 32'(sel), 32'(0));
    m_last = 2'd0;
    cyc();

    // All three requesting, memory always ready: rotating grants, no bubbles.
    req       = 3'b111;
    mem_ready = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      exp_owner = (m_last == 2'd2) ? 2'd0 : m_last + 2'd1;
      sb_q.push_back({oh(exp_owner), 1'b0});
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(oh(exp_owner)));
      chk("rr_sel", 32'(sel), 32'(exp_owner));
      chk("rr_valid", 32'(mem_valid), 32'(1));
      m_last = exp_owner;
      if (k == 5) req = 3'b000;
      cyc();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rr_idle_valid", 32'(mem_valid), 32'(0));
    chk("rr_idle_gnt", 32'(gnt), 32'(0));
    cyc();

    // Timeout on load/store: done+err in the 4th BUSY cycle.
    req = 3'b010;
    cyc();
    req = 3'b000;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) sb_q.push_back({3'b010, 1'b1});
      @(negedge clk);
      chk("to_done", 32'(done), (c == 4) ? 32'(3'b010) : 32'(0));
      chk("to_err", 32'(err), (c == 4) ? 32'(1) : 32'(0));
      chk("to_valid", 32'(mem_valid), 32'(1));
      cyc();
    end
    @(negedge clk);
    chk("to_idle_valid", 32'(mem_valid), 32'(0));
    chk("to_idle_gnt", 32'(gnt), 32'(0));
    chk("to_idle_sel", 32'(sel), 32'(1));
    cyc();

    // mem_ready arrives on the timeout cycle: normal completion, no err.
    req = 3'b001;
    cyc();
    req = 3'b000;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        mem_ready = 1'b1;
        sb_q.push_back({3'b001, 1'b0});
      end
      @(negedge clk);
      chk("tr_done", 32'(done), (c == 4) ? 32'(3'b001) : 32'(0));
      chk("tr_err", 32'(err), 32'(0));
      cyc();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("tr_idle_valid", 32'(mem_valid), 32'(0));
    cyc();

    // Reset in the middle of a debug transaction.
    req = 3'b100;
    cyc();
    @(negedge clk);
    chk("rs_gnt", 32'(gnt), 32'(3'b100));
    chk("rs_sel", 32'(sel), 32'(2));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_async_gnt", 32'(gnt), 32'(0));
    chk("rs_async_sel", 32'(sel), 32'(0));
    chk("rs_async_valid", 32'(mem_valid), 32'(0));
    chk("rs_async_done", 32'(done), 32'(0));
    chk("rs_async_err", 32'(err), 32'(0));
    req = 3'b101;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    mem_ready = 1'b1;
    req       = 3'b100;
    sb_q.push_back({3'b001, 1'b0});
    @(negedge clk);
    chk("rs_first_gnt", 32'(gnt), 32'(3'b001));
    chk("rs_first_sel", 32'(sel), 32'(0));
    cyc();
    sb_q.push_back({3'b100, 1'b0});
    req = 3'b000;
    @(negedge clk);
    chk("rs_next_gnt", 32'(gnt), 32'(3'b100));
    chk("rs_next_sel", 32'(sel), 32'(2));
    chk("rs_next_valid", 32'(mem_valid), 32'(1));
    cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rs_idle_valid", 32'(mem_valid), 32'(0));
    cyc();

    // Owner drops req in its 2nd BUSY cycle; mem_ready in the 3rd.
    req = 3'b010;
    cyc();
    @(negedge clk);
    chk("dr_c1_gnt", 32'(gnt), 32'(3'b010));
    chk("dr_c1_valid", 32'(mem_valid), 32'(1));
    cyc();
    req = 3'b000;
    @(negedge clk);
    chk("dr_c2_valid", 32'(mem_valid), 32'(1));
    chk("dr_c2_done", 32'(done), 32'(0));
    cyc();
    mem_ready = 1'b1;
    sb_q.push_back({3'b010, 1'b0});
    @(negedge clk);
    chk("dr_c3_valid", 32'(mem_valid), 32'(1));
    chk("dr_c3_done", 32'(done), 32'(3'b010));
    cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("dr_idle_valid", 32'(mem_valid), 32'(0));
    chk("dr_idle_sel", 32'(sel), 32'(1));
    cyc();

    // mem_ready while idle with no requests: ignored.
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ir_done", 32'(done), 32'(0));
    chk("ir_valid", 32'(mem_valid), 32'(0));
    chk("ir_gnt", 32'(gnt), 32'(0));
    cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("ir_after_gnt", 32'(gnt), 32'(0));
    chk("ir_after_valid", 32'(mem_valid), 32'(0));
    chk("ir_after_sel", 32'(sel), 32'(1));
    cyc();

    chk("sb_leftover", 32'(sb_q.size()), 32'(0));
    chk("sel_never_3", 32'(n_sel11), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
